// File: rtl/mul_share_ctrl.sv
// Two-requester front end for the shared iterative multiplier: round-robin grant,
// load/start sequencing, watchdog abort and a single tagged response port.
module mul_share_ctrl #(
  parameter int N       = 32,
  parameter int TIMEOUT = 68,
  parameter int CW      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [N-1:0]     req0_a,
  input  logic [N-1:0]     req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [N-1:0]     req1_a,
  input  logic [N-1:0]     req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [2*N-1:0]   rsp_p,
  output logic             rsp_err,
  output logic             mul_la,
  output logic             mul_lb,
  output logic             mul_s,
  output logic [N-1:0]     mul_a,
  output logic [N-1:0]     mul_b,
  input  logic [2*N-1:0]   mul_p,
  input  logic             mul_finish,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
  // Requesters hold valid and operands stable until their ready is seen; the response
  // holds rsp_id/rsp_p/rsp_err stable while rsp_valid is high and rsp_ready is low.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [N-1:0]     op_a, op_b;
  logic             op_id;
  logic             last_grant;
  logic [CW-1:0]    wdog;
  logic [2*N-1:0]   prod_q;
  logic             err_q;
  logic             grant0, grant1;
  logic             wdog_expired;

  // On a tie the requester that was not served last wins.
  assign grant0       = req0_valid && (!req1_valid || last_grant);
  assign grant1       = req1_valid && (!req0_valid || !last_grant);
  assign wdog_expired = (wdog == CW'(TIMEOUT - 1));

  always_comb begin
    state_nx   = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    mul_la     = 1'b0;
    mul_lb     = 1'b0;
    mul_s      = 1'b0;
    mul_a      = '0;
    mul_b      = '0;
    rsp_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0 || grant1) state_nx = S_LOAD;
      end
      S_LOAD: begin
        mul_la   = 1'b1;
        mul_lb   = 1'b1;
        mul_a    = op_a;
        mul_b    = op_b;
        state_nx = S_RUN;
      end
      S_RUN: begin
        mul_s = 1'b1;
        mul_a = op_a;
        mul_b = op_b;
        if (mul_finish || wdog_expired) state_nx = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      op_a       <= '0;
      op_b       <= '0;
      op_id      <= 1'b0;
      last_grant <= 1'b1;
      wdog       <= '0;
      prod_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (grant0) begin
            op_a       <= req0_a;
            op_b       <= req0_b;
            op_id      <= 1'b0;
            last_grant <= 1'b0;
          end else if (grant1) begin
            op_a       <= req1_a;
            op_b       <= req1_b;
            op_id      <= 1'b1;
            last_grant <= 1'b1;
          end
        end
        S_LOAD: wdog <= '0;
        S_RUN: begin
          // A finish in the same cycle as expiry still delivers the product.
          if (mul_finish) begin
            prod_q <= mul_p;
            err_q  <= 1'b0;
          end else if (wdog_expired) begin
            prod_q <= '0;
            err_q  <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_id    = op_id;
  assign rsp_p     = prod_q;
  assign rsp_err   = err_q;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

endmodule
